// File: rtl/wallace_prod_requant.sv
// Purpose: shift a 50-bit multiplier product right, round to nearest even, saturate to OUT_W bits.
// Latency: 2 cycles from input transfer to out_valid; one sample per cycle sustained.
// Backpressure: valid/ready with 2 samples of skid; in_ready drops only when both stages are full and out_ready is low.
module wallace_prod_requant #(
    parameter int IN_W  = 50,
    parameter int OUT_W = 16,
    parameter int SH_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_prod,
    input  logic [SH_W-1:0]  in_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_inexact
);

    // Stage 1 holds the shifted quotient plus guard/sticky bits; stage 2 holds the final result.
    logic            s1_valid_q, s1_valid_d;
    logic [IN_W-1:0] s1_quo_q, s1_quo_d;
    logic            s1_guard_q, s1_guard_d;
    logic            s1_sticky_q, s1_sticky_d;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic             out_inexact_q, out_inexact_d;

    logic            in_xfer;
    logic            out_xfer;
    logic            s2_load;
    logic [IN_W-1:0] quo;
    logic            guard;
    logic            sticky;
    logic            rnd_up;
    logic [IN_W:0]   rounded;
    logic            ovf;

    // Handshake: stage 2 takes stage 1 whenever it is empty or draining, so no bubbles appear.
    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid_q && out_ready;
    end

    // Stage-1 datapath: quotient, guard bit (last bit shifted out) and sticky OR of the bits below it.
    always_comb begin
        quo    = in_prod >> in_shift;
        guard  = 1'b0;
        sticky = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (i + 1 == int'(in_shift)) begin
                guard = in_prod[i];
            end
            if (i + 1 < int'(in_shift)) begin
                sticky = sticky | in_prod[i];
            end
        end
    end

    // Stage-2 datapath: round half to even, then clamp anything that no longer fits in OUT_W bits.
    always_comb begin
        rnd_up  = s1_guard_q & (s1_sticky_q | s1_quo_q[0]);
        rounded = {1'b0, s1_quo_q} + {{IN_W{1'b0}}, rnd_up};
        ovf     = |rounded[IN_W:OUT_W];
    end

    // Next-state for both stages: load on transfer, otherwise hold.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_quo_d      = s1_quo_q;
        s1_guard_d    = s1_guard_q;
        s1_sticky_d   = s1_sticky_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sat_d     = out_sat_q;
        out_inexact_d = out_inexact_q;

        if (in_xfer) begin
            s1_valid_d  = 1'b1;
            s1_quo_d    = quo;
            s1_guard_d  = guard;
            s1_sticky_d = sticky;
        end else if (s2_load) begin
            s1_valid_d  = 1'b0;
        end

        if (s2_load) begin
            out_valid_d   = 1'b1;
            out_data_d    = ovf ? {OUT_W{1'b1}} : rounded[OUT_W-1:0];
            out_sat_d     = ovf;
            out_inexact_d = s1_guard_q | s1_sticky_q;
        end else if (out_xfer) begin
            out_valid_d   = 1'b0;
        end
    end

    // Pipeline registers; reset flushes both stages immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_quo_q      <= '0;
            s1_guard_q    <= 1'b0;
            s1_sticky_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sat_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_quo_q      <= s1_quo_d;
            s1_guard_q    <= s1_guard_d;
            s1_sticky_q   <= s1_sticky_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sat_q     <= out_sat_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign out_inexact = out_inexact_q;

endmodule
